// File: rtl/stack_seq_pkg.sv
// rtl/stack_seq_pkg.sv - shared types and sizing helpers for the frame-reversal sequencer
package stack_seq_pkg;

   typedef enum logic {FILL = 1'b0, DRAIN = 1'b1} seq_state_t;

   localparam int RD_LATENCY_DEF = 2;
   localparam int SKID_DEPTH     = RD_LATENCY_DEF + 1;

   // Width of the word counters for a given stack depth.
   function automatic int cnt_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // Skid entries needed to absorb every pop still in the stack read pipeline.
   function automatic int skid_depth(input int rd_latency);
      return rd_latency + 1;
   endfunction

endpackage

// File: rtl/stack_seq_skid.sv
// rtl/stack_seq_skid.sv - small synchronous FIFO with occupancy carrying {last, data}
module stack_seq_skid #(
   parameter int WIDTH = 33,
   parameter int N     = 3,
   parameter int OW    = $clog2(N + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             wr_valid,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_take,
   output logic             rd_valid,
   output logic [WIDTH-1:0] rd_data,
   output logic [OW-1:0]    occ
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [WIDTH-1:0] mem [2**PW];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             rd_fire;

   assign rd_valid = (occ != '0);
   assign rd_fire  = rd_take & rd_valid;
   assign rd_data  = mem[rd_ptr];

   // Entry storage; contents are only observed while occupied, so no reset.
   always_ff @(posedge clock) begin
      if (wr_valid) mem[wr_ptr] <= wr_data;
   end

   // Pointer and occupancy bookkeeping; the writer's credit scheme keeps occ <= N.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (wr_valid) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire)  rd_ptr <= rd_ptr + 1'b1;
         case ({wr_valid, rd_fire})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/stack_seq_ctrl.sv
// rtl/stack_seq_ctrl.sv - frame-reversal sequencer on the LIFO push/pop port; optional checks under STACK_SEQ_CHK_EN
module stack_seq_ctrl
   import stack_seq_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 32,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  frame_trunc,
   output logic                  stk_push,
   output logic                  stk_pop,
   output logic [DATA_WIDTH-1:0] stk_wdata,
   input  logic [DATA_WIDTH-1:0] stk_rdata,
   input  logic                  stk_empty,
   input  logic                  stk_full,
   output logic                  seq_err
);
   localparam int CW     = cnt_w(DEPTH);
   localparam int SKID_N = skid_depth(RD_LATENCY);
   localparam int OW     = $clog2(SKID_N + 1);
   localparam int UW     = OW + 1;
   localparam logic [CW-1:0] CAP      = CW'(DEPTH - 1);
   localparam logic [UW-1:0] SKID_LIM = UW'(SKID_N);

   seq_state_t            state;
   logic [CW-1:0]         count;
   logic                  in_ready_q;
   logic                  trunc_q;
   logic [RD_LATENCY-1:0] sr_vld;
   logic [RD_LATENCY-1:0] sr_last;
   logic [OW-1:0]         occ;
   logic [OW-1:0]         inflight;
   logic [UW-1:0]         used;
   logic                  accept;
   logic                  pop;
   logic                  take;
   logic                  last_fire;
   logic                  sk_valid;
   logic [DATA_WIDTH:0]   sk_data;

   assign accept      = in_valid & in_ready_q;
   assign in_ready    = in_ready_q;
   assign stk_push    = accept;
   assign stk_wdata   = accept ? in_data : '0;
   assign stk_pop     = pop;
   assign take        = sk_valid & out_ready;
   assign last_fire   = take & sk_data[DATA_WIDTH];
   assign out_valid   = sk_valid;
   assign out_data    = sk_valid ? sk_data[DATA_WIDTH-1:0] : '0;
   assign out_last    = sk_valid & sk_data[DATA_WIDTH];
   assign frame_trunc = trunc_q;

   // Number of pops still travelling through the stack read pipeline.
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + OW'(sr_vld[i]);
   end

   // Pop credit: a word leaving the skid this cycle frees its slot for a new pop.
   always_comb begin
      used = UW'(occ) + UW'(inflight) - UW'(take);
      pop  = (state == DRAIN) && (count != '0) && (used < SKID_LIM);
   end

   // Read-latency shift register; the tag marks the pop that empties the frame.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr_vld  <= '0;
         sr_last <= '0;
      end else begin
         sr_vld[0]  <= pop;
         sr_last[0] <= pop && (count == CW'(1));
         for (int i = 1; i < RD_LATENCY; i++) begin
            sr_vld[i]  <= sr_vld[i-1];
            sr_last[i] <= sr_last[i-1];
         end
      end
   end

   stack_seq_skid #(
      .WIDTH (DATA_WIDTH + 1),
      .N     (SKID_N),
      .OW    (OW)
   ) u_skid (
      .clock    (clock),
      .reset    (reset),
      .wr_valid (sr_vld[RD_LATENCY-1]),
      .wr_data  ({sr_last[RD_LATENCY-1], stk_rdata}),
      .rd_take  (out_ready),
      .rd_valid (sk_valid),
      .rd_data  (sk_data),
      .occ      (occ)
   );

   // Fill/drain sequencing; count holds words stored in FILL and words left to pop in DRAIN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= FILL;
         count      <= '0;
         in_ready_q <= 1'b0;
         trunc_q    <= 1'b0;
      end else begin
         trunc_q <= 1'b0;
         case (state)
            FILL: begin
               if (accept) begin
                  count <= count + 1'b1;
                  if (in_last || (count == CAP - 1'b1)) begin
                     state      <= DRAIN;
                     in_ready_q <= 1'b0;
                     trunc_q    <= ~in_last;
                  end else begin
                     in_ready_q <= 1'b1;
                  end
               end else begin
                  in_ready_q <= (count < CAP);
               end
            end
            DRAIN: begin
               in_ready_q <= 1'b0;
               if (pop) count <= count - 1'b1;
               if (last_fire && (occ == OW'(1)) && (inflight == '0)) begin
                  state      <= FILL;
                  count      <= '0;
                  in_ready_q <= 1'b1;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifdef STACK_SEQ_CHK_EN
   logic was_drain;
   logic err_q;
   logic chk_hit;

   // Conditions where the controller and the stack disagree about occupancy.
   always_comb begin
      chk_hit = ((state == FILL) && stk_full && (count < CAP)) ||
                ((state == FILL) && was_drain && !stk_empty) ||
                (pop && stk_empty);
   end

   // Sticky error flag plus previous-state memory for FILL-entry detection.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         was_drain <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         was_drain <= (state == DRAIN);
         err_q     <= err_q | chk_hit;
      end
   end

`ifndef SYNTHESIS
   // Simulation report raised alongside the sticky flag.
   always @(posedge clock) begin
      if (!reset && chk_hit) $error("stack_seq_ctrl: stack occupancy disagrees with sequencer");
   end
`endif

   assign seq_err = err_q;
`else
   logic unused_flags;
   assign unused_flags = stk_empty ^ stk_full;
   assign seq_err      = 1'b0;
`endif

endmodule

// File: tb/tb_stack_seq_ctrl.sv
// tb/tb_stack_seq_ctrl.sv - randomized scoreboard bench for stack_seq_ctrl with a behavioural stack
module tb_stack_seq_ctrl;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int RDL   = 2;
   localparam int CAP   = DEPTH - 1;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          frame_trunc;
   logic          stk_push;
   logic          stk_pop;
   logic [DW-1:0] stk_wdata;
   logic [DW-1:0] stk_rdata;
   logic          stk_empty;
   logic          stk_full;
   logic          seq_err;

   always #5 clock = ~clock;

   stack_seq_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(RDL)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .frame_trunc(frame_trunc),
      .stk_push(stk_push), .stk_pop(stk_pop), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
      .stk_empty(stk_empty), .stk_full(stk_full), .seq_err(seq_err)
   );

   // Behavioural LIFO: full when the pointer is all ones, read data two cycles after pop.
   logic [DW-1:0] smem [DEPTH];
   logic [2:0]    sptr;
   logic [DW-1:0] rd0, rd1;
   logic          force_empty = 1'b0;

   assign stk_empty = force_empty || (sptr == 3'd0);
   assign stk_full  = (sptr == 3'(DEPTH - 1));
   assign stk_rdata = rd1;

   always @(posedge clock) begin
      if (!reset && stk_push) smem[sptr] <= stk_wdata;
   end

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         sptr <= '0;
         rd0  <= '0;
         rd1  <= '0;
      end else begin
         if (stk_push) sptr <= sptr + 3'd1;
         else if (stk_pop) begin
            rd0  <= smem[sptr - 3'd1];
            sptr <= sptr - 3'd1;
         end
         rd1 <= rd0;
      end
   end

   // Reference model: frames end on last or at capacity, then come back reversed.
   logic [DW:0]   exp_q [$];
   logic [DW-1:0] cur [$];
   int exp_trunc  = 0;
   int seen_trunc = 0;
   int checks     = 0;
   int failures   = 0;
   int out_mode   = 0;
   bit done       = 1'b0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_accept(input logic [DW-1:0] d, input logic l);
      cur.push_back(d);
      if (l || cur.size() == CAP) begin
         if (!l) exp_trunc++;
         for (int i = cur.size() - 1; i >= 0; i--) exp_q.push_back({(i == 0), cur[i]});
         cur.delete();
      end
   endfunction

   // Output scoreboard and stall-stability monitor, sampled mid-cycle.
   logic          prev_stall = 1'b0;
   logic [DW:0]   prev_word  = '0;
   always @(negedge clock) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         if (frame_trunc) seen_trunc++;
         if (prev_stall) begin
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_word", {out_last, out_data}, prev_word);
         end
         if (out_valid && out_ready) begin
            check_eq("out_expected_avail", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check_eq("out_word", {out_last, out_data}, exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_word  = {out_last, out_data};
      end
   end

   // Downstream ready pattern: 0 high, 1 low, 2 toggle, 3 random.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         case (out_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            2:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   task automatic send_word(input logic [DW-1:0] d, input logic l);
      int n = 0;
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!ok && n < 2000) begin
         @(negedge clock);
         if (in_ready) ok = 1'b1;
         else n++;
      end
      check_eq("send_accepted", ok, 1);
      if (ok) begin
         @(posedge clock);
         #1;
         model_accept(d, l);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || !in_ready) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check_eq(tag, n < 3000, 1);
      @(posedge clock);
      #1;
   endtask

   initial begin
      #500000;
      check_eq("global_timeout_done", done, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int n;
      // Reset state.
      repeat (3) @(posedge clock);
      #1;
      check_eq("rst_in_ready", in_ready, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_stk_push", stk_push, 0);
      check_eq("rst_stk_pop", stk_pop, 0);
      check_eq("rst_frame_trunc", frame_trunc, 0);
      check_eq("rst_seq_err", seq_err, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      check_eq("in_ready_after_rst", in_ready, 1);

      // Three-word frame, latency and back-to-back output.
      out_mode = 0;
      send_word(32'h11, 1'b0);
      send_word(32'h22, 1'b0);
      send_word(32'h33, 1'b1);
      n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!out_valid && n < 20);
      check_eq("first_out_latency", n - 1, 3);
      check_eq("first_out_data", out_data, 32'h33);
      @(negedge clock);
      check_eq("burst_valid_1", out_valid, 1);
      @(negedge clock);
      check_eq("burst_valid_2", out_valid, 1);
      check_eq("burst_last", out_last, 1);
      wait_idle("idle_after_3word");

      // One-word frame.
      send_word(32'hAA, 1'b1);
      wait_idle("idle_after_single");
      check_eq("in_ready_after_single", in_ready, 1);

      // Nine words without last, then a closing word: capacity truncation.
      n = seen_trunc;
      for (int i = 1; i <= 9; i++) send_word(DW'(i), 1'b0);
      send_word(32'h0A, 1'b1);
      wait_idle("idle_after_trunc");
      check_eq("trunc_pulses", seen_trunc - n, 1);

      // Seven-word frame under alternating backpressure.
      out_mode = 2;
      for (int i = 0; i < 7; i++) send_word($urandom, i == 6);
      wait_idle("idle_after_toggle");
      out_mode = 0;
      check_eq("seq_err_after_toggle", seq_err, 0);

      // Reset while draining with four words still in the stack.
      out_mode = 1;
      for (int i = 0; i < 7; i++) send_word(32'hC0 + DW'(i), i == 6);
      repeat (8) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check_eq("mid_rst_in_ready", in_ready, 0);
      check_eq("mid_rst_out_valid", out_valid, 0);
      check_eq("mid_rst_out_data", out_data, 0);
      check_eq("mid_rst_out_last", out_last, 0);
      check_eq("mid_rst_stk_pop", stk_pop, 0);
      check_eq("mid_rst_stk_push", stk_push, 0);
      check_eq("mid_rst_seq_err", seq_err, 0);
      exp_q.delete();
      cur.delete();
      out_mode = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      send_word(32'hB1, 1'b0);
      send_word(32'hB2, 1'b1);
      wait_idle("idle_after_mid_rst");

      // Randomized frames, gaps and backpressure.
      out_mode = 3;
      for (int f = 0; f < 25; f++) begin
         int len;
         len = $urandom_range(1, 10);
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               repeat ($urandom_range(1, 3)) @(posedge clock);
               #1;
            end
            send_word($urandom, i == len - 1);
         end
      end
      wait_idle("idle_after_random");
      out_mode = 0;
      check_eq("trunc_total", seen_trunc, exp_trunc);
      check_eq("stack_drained", stk_empty, 1);
      check_eq("seq_err_final", seq_err, 0);

`ifdef STACK_SEQ_CHK_EN
      // Stack claims empty while the sequencer still has words to pop.
      out_mode = 1;
      send_word(32'h51, 1'b0);
      send_word(32'h52, 1'b1);
      force_empty = 1'b1;
      repeat (3) @(negedge clock);
      check_eq("chk_seq_err_set", seq_err, 1);
      force_empty = 1'b0;
      repeat (5) @(negedge clock);
      check_eq("chk_seq_err_held", seq_err, 1);
      @(posedge clock);
      #1;
      reset = 1'b1;
      exp_q.delete();
      cur.delete();
      #1;
      check_eq("chk_seq_err_cleared", seq_err, 0);
      out_mode = 0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
`endif

      done = 1'b1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
